// File: rtl/gray_mon_pkg.sv
// Shared types and helpers for the Gray-code sequence monitor.
// Contains the code width, the monitor state encoding and the Gray-to-binary function.
package gray_mon_pkg;

    localparam int CODE_W = 3;

    typedef enum logic [1:0] {MON_WAIT, MON_LOCK, MON_ERR} mon_state_t;

    function automatic logic [2:0] gray2bin(logic [2:0] g);
        return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational 3-bit Gray-to-binary converter.
// This module is a thin wrapper around gray2bin so the top level stays readable.
module gray_to_bin
    import gray_mon_pkg::*;
(
    input  logic [2:0] g,
    output logic [2:0] b
);

    assign b = gray2bin(g);

endmodule

// File: rtl/gray_seq_monitor.sv
// Tracks a 3-bit Gray sequencer and flags illegal steps. It also counts wraps and errors.
// When GRAY_MON_STICKY_EN is defined, ERR is terminal until gcnt.
module gray_seq_monitor
    import gray_mon_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             gcnt,
    input  logic             x,
    input  logic             y,
    input  logic             z,
    output logic [2:0]       bin,
    output logic             locked,
    output logic             step_err,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic [ERR_W-1:0] err_cnt
);

    function automatic logic [ERR_W-1:0] sat_inc(logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [2:0] s_p0;
    logic [2:0] prev_p1;
    logic [2:0] expected_p0;
    mon_state_t state_p1, state_nx;
    logic       wrap_ev_p0;
    logic       err_ev_p0;

    // Stage 0: combinational conversion and transition classification
    gray_to_bin u_g2b (
        .g ({x, y, z}),
        .b (s_p0)
    );

    assign expected_p0 = prev_p1 + 3'd1;

    always_comb begin
        state_nx   = state_p1;
        wrap_ev_p0 = 1'b0;
        err_ev_p0  = 1'b0;
        case (state_p1)
            MON_WAIT: begin
                if (s_p0 == 3'd0)
                    state_nx = MON_LOCK;
            end
            MON_LOCK: begin
                if (s_p0 == expected_p0) begin
                    if (prev_p1 == 3'd7 && s_p0 == 3'd0)
                        wrap_ev_p0 = 1'b1;
                end else if (s_p0 != prev_p1) begin
                    state_nx  = MON_ERR;
                    err_ev_p0 = 1'b1;
                end
            end
            MON_ERR: begin
`ifdef GRAY_MON_STICKY_EN
                state_nx = MON_ERR;
`else
                if (s_p0 == 3'd0)
                    state_nx = MON_LOCK;
`endif
            end
            default: state_nx = MON_WAIT;
        endcase
    end

    // Stage 1: registered state, outputs and counters
    always_ff @(posedge clk) begin
        if (gcnt) begin
            state_p1 <= MON_WAIT;
            prev_p1  <= 3'd0;
            bin      <= 3'd0;
            locked   <= 1'b0;
            step_err <= 1'b0;
            wrap_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            state_p1 <= state_nx;
            prev_p1  <= s_p0;
            bin      <= s_p0;
            locked   <= (state_nx == MON_LOCK);
            step_err <= err_ev_p0;
            if (wrap_ev_p0)
                wrap_cnt <= wrap_cnt + 1'b1;
            if (err_ev_p0)
                err_cnt <= sat_inc(err_cnt);
        end
    end

endmodule
